xnor_popcount_acc: RTL and testbench

- Parametrised, pipelined XNOR-popcount engine with vector accumulation, for binarised-NN dot products.
- Accepts one N-bit activation/weight chunk per cycle, with a per-bit mask for partial chunks.
- Accumulates popcounts over a multi-beat vector delimited by in_last.
- Emits the popcount, the active-bit count, the bipolar dot product, a threshold (sign) bit and an overflow flag.
- Sits between the activation/weight buffers and the activation/next-layer logic.

---
 rtl/xnor_popcount_acc.sv | 154 +++++++++++++++
 tb/tb_xnor_popcount_acc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_popcount_acc.sv
// XNOR-popcount engine with multi-beat vector accumulation for binarised-NN dot products.
// Ports: clk/rst (sync, active-high); in_valid/in_last/xi/wi/in_mask/th per-beat inputs;
//        out_valid pulse with out_pop/out_cnt/out_dot/out_bin/out_ovf registered results.
module xnor_popcount_acc #(
    parameter int N         = 256,
    parameter int PIPE      = 2,
    parameter int MAX_BEATS = 4,
    parameter int ACC_W     = $clog2(N*MAX_BEATS+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [N-1:0]            xi,
    input  logic [N-1:0]            wi,
    input  logic [N-1:0]            in_mask,
    input  logic signed [ACC_W:0]   th,
    output logic                    out_valid,
    output logic [ACC_W-1:0]        out_pop,
    output logic [ACC_W-1:0]        out_cnt,
    output logic signed [ACC_W:0]   out_dot,
    output logic                    out_bin,
    output logic                    out_ovf
);

    localparam int L  = $clog2(N);
    localparam int CW = L + 1;
    localparam logic [ACC_W-1:0] MAXV = '1;

    // Level k of the tree holds N>>k partial sums. A level is registered
    // when floor(k*PIPE/L) steps, which spreads PIPE registers evenly and
    // always registers the root.
    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int M = N >> k;
        localparam bit REG = (k > 0) && ((k*PIPE)/L != ((k-1)*PIPE)/L);
        logic [CW-1:0] pop [M];
        logic [CW-1:0] cnt [M];
        if (k == 0) begin : g_leaf
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    pop[i] = CW'((xi[i] ~^ wi[i]) & in_mask[i]);
                    cnt[i] = CW'(in_mask[i]);
                end
            end
        end else begin : g_node
            logic [CW-1:0] pop_c [M];
            logic [CW-1:0] cnt_c [M];
            always_comb begin
                for (int i = 0; i < M; i++) begin
                    pop_c[i] = g_lvl[k-1].pop[2*i] + g_lvl[k-1].pop[2*i+1];
                    cnt_c[i] = g_lvl[k-1].cnt[2*i] + g_lvl[k-1].cnt[2*i+1];
                end
            end
            if (REG) begin : g_reg
                always_ff @(posedge clk) begin
                    pop <= pop_c;
                    cnt <= cnt_c;
                end
            end else begin : g_comb
                always_comb begin
                    pop = pop_c;
                    cnt = cnt_c;
                end
            end
        end
    end

    // Side-band pipeline matching the tree's register levels.
    logic [PIPE-1:0]        vld_p;
    logic [PIPE-1:0]        last_p;
    logic signed [ACC_W:0]  th_p [PIPE];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= in_valid;
            last_p[0] <= in_valid & in_last;
            for (int s = 1; s < PIPE; s++) begin
                vld_p[s]  <= vld_p[s-1];
                last_p[s] <= last_p[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        th_p[0] <= th;
        for (int s = 1; s < PIPE; s++) begin
            th_p[s] <= th_p[s-1];
        end
    end

    // Accumulator stage.
    logic [ACC_W-1:0]      acc_pop;
    logic [ACC_W-1:0]      acc_cnt;
    logic                  ovf;
    logic                  fresh;
    logic [ACC_W-1:0]      b_pop;
    logic [ACC_W-1:0]      b_cnt;
    logic [ACC_W:0]        s_pop;
    logic [ACC_W:0]        s_cnt;
    logic [ACC_W-1:0]      n_pop;
    logic [ACC_W-1:0]      n_cnt;
    logic                  n_ovf;
    logic signed [ACC_W:0] n_dot;
    logic                  n_bin;

    always_comb begin
        b_pop = ACC_W'(g_lvl[L].pop[0]);
        b_cnt = ACC_W'(g_lvl[L].cnt[0]);
        s_pop = {1'b0, fresh ? '0 : acc_pop} + {1'b0, b_pop};
        s_cnt = {1'b0, fresh ? '0 : acc_cnt} + {1'b0, b_cnt};
        n_pop = s_pop[ACC_W] ? MAXV : s_pop[ACC_W-1:0];
        n_cnt = s_cnt[ACC_W] ? MAXV : s_cnt[ACC_W-1:0];
        n_ovf = (~fresh & ovf) | s_pop[ACC_W] | s_cnt[ACC_W];
        // 2*pop - cnt always lies in [-cnt, cnt], so modulo 2^(ACC_W+1)
        // arithmetic gives the exact signed result.
        n_dot = {n_pop, 1'b0} - {1'b0, n_cnt};
        n_bin = n_dot >= th_p[PIPE-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_pop   <= '0;
            acc_cnt   <= '0;
            ovf       <= 1'b0;
            fresh     <= 1'b1;
            out_valid <= 1'b0;
            out_pop   <= '0;
            out_cnt   <= '0;
            out_dot   <= '0;
            out_bin   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (vld_p[PIPE-1]) begin
                acc_pop <= n_pop;
                acc_cnt <= n_cnt;
                ovf     <= n_ovf;
                fresh   <= last_p[PIPE-1];
                if (last_p[PIPE-1]) begin
                    out_valid <= 1'b1;
                    out_pop   <= n_pop;
                    out_cnt   <= n_cnt;
                    out_dot   <= n_dot;
                    out_bin   <= n_bin;
                    out_ovf   <= n_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Bench for xnor_popcount_acc: two instances (MAX_BEATS 4 and 2) on shared stimulus,
// checked every cycle against a vector-level model plus literal expectations.
module tb_xnor_popcount_acc;

    localparam int N    = 256;
    localparam int PIPE = 2;
    localparam int AW1  = 11;
    localparam int AW2  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [N-1:0] xi = '0;
    logic [N-1:0] wi = '0;
    logic [N-1:0] in_mask = '0;
    logic signed [AW1:0] th1 = '0;
    logic signed [AW2:0] th2 = '0;

    logic ov1, ob1, of1;
    logic [AW1-1:0] op1, oc1;
    logic signed [AW1:0] od1;
    logic ov2, ob2, of2;
    logic [AW2-1:0] op2, oc2;
    logic signed [AW2:0] od2;

    xnor_popcount_acc #(.N(N), .PIPE(PIPE), .MAX_BEATS(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .xi(xi), .wi(wi), .in_mask(in_mask), .th(th1),
        .out_valid(ov1), .out_pop(op1), .out_cnt(oc1), .out_dot(od1),
        .out_bin(ob1), .out_ovf(of1)
    );

    xnor_popcount_acc #(.N(N), .PIPE(PIPE), .MAX_BEATS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .xi(xi), .wi(wi), .in_mask(in_mask), .th(th2),
        .out_valid(ov2), .out_pop(op2), .out_cnt(oc2), .out_dot(od2),
        .out_bin(ob2), .out_ovf(of2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endfunction

    typedef struct {
        int pop;
        int cnt;
        int dot;
        int bin;
        int ovf;
    } res_t;

    typedef struct {
        int   due;
        res_t r0;
        res_t r1;
    } exp_t;

    exp_t q[$];
    int   m_pop [2];
    int   m_cnt [2];
    int   m_ovf [2];
    int   aw [2];
    bit   m_fresh = 1'b1;
    res_t hold [2];
    bit   run = 1'b0;
    int   rst_due = -1;

    initial begin
        aw[0] = AW1;
        aw[1] = AW2;
        for (int i = 0; i < 2; i++) begin
            m_pop[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 0;
            hold[i] = '{0, 0, 0, 0, 0};
        end
    end

    task automatic model_beat(bit l, int t);
        int pb;
        int cb;
        res_t r [2];
        pb = $countones(~(xi ^ wi) & in_mask);
        cb = $countones(in_mask);
        for (int i = 0; i < 2; i++) begin
            int mx;
            mx = (1 << aw[i]) - 1;
            if (m_fresh) begin
                m_pop[i] = 0;
                m_cnt[i] = 0;
                m_ovf[i] = 0;
            end
            m_pop[i] += pb;
            m_cnt[i] += cb;
            if (m_pop[i] > mx) begin
                m_pop[i] = mx;
                m_ovf[i] = 1;
            end
            if (m_cnt[i] > mx) begin
                m_cnt[i] = mx;
                m_ovf[i] = 1;
            end
            r[i].pop = m_pop[i];
            r[i].cnt = m_cnt[i];
            r[i].dot = 2 * m_pop[i] - m_cnt[i];
            r[i].bin = (r[i].dot >= t) ? 1 : 0;
            r[i].ovf = m_ovf[i];
        end
        m_fresh = l;
        if (l) q.push_back('{cyc + PIPE + 1, r[0], r[1]});
    endtask

    task automatic drive(bit v, bit l, logic [N-1:0] x,
                         logic [N-1:0] w, logic [N-1:0] m, int t);
        @(posedge clk);
        #1;
        in_valid = v;
        in_last = l;
        xi = x;
        wi = w;
        in_mask = m;
        th1 = t[AW1:0];
        th2 = t[AW2:0];
        if (v && !rst) model_beat(l, t);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, xi, wi, in_mask, 0);
    endtask

    task automatic do_reset(bit v, bit l);
        exp_t k[$];
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = v;
        in_last = l;
        rst_due = cyc + 1;
        foreach (q[i]) if (q[i].due <= cyc) k.push_back(q[i]);
        q = k;
        m_fresh = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_lit(string nm, int inst, int p, int c, int d, int b, int o);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(inst == 0 ? ov1 : ov2) && n < 10);
        if (!(inst == 0 ? ov1 : ov2)) begin
            chk({nm, "_timeout"}, 0, 1);
        end else if (inst == 0) begin
            chk({nm, "_pop"}, int'(op1), p);
            chk({nm, "_cnt"}, int'(oc1), c);
            chk({nm, "_dot"}, int'(od1), d);
            chk({nm, "_bin"}, int'(ob1), b);
            chk({nm, "_ovf"}, int'(of1), o);
        end else begin
            chk({nm, "_pop"}, int'(op2), p);
            chk({nm, "_cnt"}, int'(oc2), c);
            chk({nm, "_dot"}, int'(od2), d);
            chk({nm, "_bin"}, int'(ob2), b);
            chk({nm, "_ovf"}, int'(of2), o);
        end
    endtask

    // Per-cycle comparison against the model for both instances.
    bit ev;
    always @(negedge clk) begin
        if (run) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            if (cyc == rst_due) begin
                hold[0] = '{0, 0, 0, 0, 0};
                hold[1] = '{0, 0, 0, 0, 0};
            end
            if (ev) begin
                hold[0] = q[0].r0;
                hold[1] = q[0].r1;
                void'(q.pop_front());
            end
            chk("m_valid1", int'(ov1), int'(ev));
            chk("m_pop1", int'(op1), hold[0].pop);
            chk("m_cnt1", int'(oc1), hold[0].cnt);
            chk("m_dot1", int'(od1), hold[0].dot);
            chk("m_bin1", int'(ob1), hold[0].bin);
            chk("m_ovf1", int'(of1), hold[0].ovf);
            chk("m_valid2", int'(ov2), int'(ev));
            chk("m_pop2", int'(op2), hold[1].pop);
            chk("m_cnt2", int'(oc2), hold[1].cnt);
            chk("m_dot2", int'(od2), hold[1].dot);
            chk("m_bin2", int'(ob2), hold[1].bin);
            chk("m_ovf2", int'(of2), hold[1].ovf);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [N-1:0] ones;
    logic [N-1:0] r;
    logic [N-1:0] m64;
    logic [N-1:0] d;

    initial begin
        ones = '1;
        r = {8{$urandom()}};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // Single beat, all match.
        drive(1'b1, 1'b1, r, r, ones, 0);
        idle();
        wait_lit("t1", 0, 256, 256, 256, 1, 0);

        // Single beat, all mismatch.
        drive(1'b1, 1'b1, ~r, r, ones, 0);
        idle();
        wait_lit("t2", 0, 0, 256, -256, 0, 0);

        // Two beats: 100 matches, then 32 of 64 masked bits match.
        m64 = ones >> 192;
        d = m64 & ~(ones >> 224);
        drive(1'b1, 1'b0, r ^ (ones << 100), r, ones, 0);
        drive(1'b1, 1'b1, r ^ d, r, m64, -56);
        idle();
        wait_lit("t3", 0, 132, 320, -56, 1, 0);

        // Gapped 3-beat vector then an immediate single-beat vector.
        drive(1'b1, 1'b0, r ^ (ones << 10), r, ones, 0);
        idle();
        idle();
        drive(1'b1, 1'b0, r ^ (ones << 20), r, ones, 0);
        idle();
        idle();
        drive(1'b1, 1'b1, r ^ (ones << 30), r, ones, -647);
        drive(1'b1, 1'b1, r, r, ones >> 240, 16);
        idle();
        wait_lit("t4a", 0, 60, 768, -648, 0, 0);
        wait_lit("t4b", 0, 16, 16, 16, 1, 0);

        // Five full beats: saturates the MAX_BEATS=2 instance only.
        for (int i = 0; i < 5; i++) drive(1'b1, i == 4, r, r, ones, 0);
        idle();
        wait_lit("t5", 1, 1023, 1023, 1023, 1, 1);
        chk("t5_pop_wide", int'(op1), 1280);
        chk("t5_ovf_wide", int'(of1), 0);
        drive(1'b1, 1'b1, r, r, ones, 0);
        idle();
        wait_lit("t5b", 1, 256, 256, 256, 1, 0);

        // Reset mid-vector, with a last beat presented during reset.
        drive(1'b1, 1'b0, r, r, ones, 0);
        drive(1'b1, 1'b0, r, r, ones, 0);
        do_reset(1'b1, 1'b1);
        repeat (4) idle();
        chk("t6_valid", int'(ov1), 0);
        chk("t6_pop", int'(op1), 0);
        chk("t6_cnt", int'(oc1), 0);
        chk("t6_dot", int'(od1), 0);
        chk("t6_bin", int'(ob1), 0);
        drive(1'b1, 1'b1, r, r, ones, 0);
        idle();
        wait_lit("t6b", 0, 256, 256, 256, 1, 0);

        repeat (5) idle();
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
